// File: rtl/pixel_arb_pkg.sv
// Shared types and helpers for the pixel source arbiter.
//   SRC_NUM   : number of pixel sources sharing the mux
//   src_idx_t : source index / grant / mux select type
//   state_t   : arbiter FSM state
//   rr_pick   : round-robin pick of the first requester at or after ptr
package pixel_arb_pkg;

  localparam int SRC_NUM = 4;

  typedef logic [1:0] src_idx_t;

  typedef enum logic {IDLE, BURST} state_t;

  // Walk offsets from farthest to nearest so the nearest requester at or
  // after ptr is the last one written. Callers check |req themselves.
  function automatic src_idx_t rr_pick(input logic [SRC_NUM-1:0] req,
                                       input src_idx_t ptr);
    src_idx_t idx;
    rr_pick = ptr;
    for (int k = SRC_NUM - 1; k >= 0; k--) begin
      idx = ptr + src_idx_t'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/pixel_mux4.sv
// Combinational 4:1 pixel multiplexer.
//   din  : packed array of source pixels, din[i] belongs to source i
//   sel  : source select
//   dout : selected pixel
module pixel_mux4
  import pixel_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [SRC_NUM-1:0][DATA_W-1:0] din,
  input  src_idx_t                       sel,
  output logic [DATA_W-1:0]              dout
);

  assign dout = din[sel];

endmodule

// File: rtl/pixel_src_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4:1 pixel mux between four
// sources. A grant lasts up to BURST_LEN beats or until the granted source
// flags end-of-line; the selected pixel is registered onto one valid/ready
// output stream.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_data0..3         : source pixels
//   in_valid/in_last    : per-source valid and end-of-line
//   in_ready            : per-source ready, at most one bit set
//   sel                 : mux select (current grant)
//   out_data/last/src   : registered beat, its end-of-line flag and source
//   out_valid/out_ready : output handshake
module pixel_src_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    in_data0,
  input  logic [DATA_W-1:0]    in_data1,
  input  logic [DATA_W-1:0]    in_data2,
  input  logic [DATA_W-1:0]    in_data3,
  input  logic [SRC_NUM-1:0]   in_valid,
  input  logic [SRC_NUM-1:0]   in_last,
  output logic [SRC_NUM-1:0]   in_ready,
  output src_idx_t             sel,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  output logic                 out_last,
  output src_idx_t             out_src,
  input  logic                 out_ready
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

  state_t                        state, state_nxt;
  src_idx_t                      grant, rr_ptr;
  logic [CNT_W-1:0]              beat_cnt;
  logic [SRC_NUM-1:0][DATA_W-1:0] din;
  logic [DATA_W-1:0]             mux_data;
  logic                          out_free, xfer, burst_end;

  assign din = {in_data3, in_data2, in_data1, in_data0};

  pixel_mux4 #(.DATA_W(DATA_W)) u_mux (
    .din  (din),
    .sel  (grant),
    .dout (mux_data)
  );

  assign sel       = grant;
  // Output register can take a beat when empty or draining this cycle.
  assign out_free  = !out_valid || out_ready;
  assign xfer      = (state == BURST) && in_valid[grant] && out_free;
  // Last flag and count limit on the same beat collapse into one end.
  assign burst_end = xfer && (in_last[grant] || beat_cnt == CNT_MAX);

  always_comb begin
    state_nxt = state;
    in_ready  = '0;
    case (state)
      IDLE:    if (|in_valid) state_nxt = BURST;
      BURST: begin
        in_ready[grant] = out_free;
        if (burst_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |in_valid) begin
        grant    <= rr_pick(in_valid, rr_ptr);
        beat_cnt <= '0;
      end else if (burst_end) begin
        beat_cnt <= '0;
        rr_ptr   <= grant + 2'd1;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_last  <= in_last[grant];
      out_src   <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_src_arbiter.sv
// Scoreboard bench for pixel_src_arbiter: per-source pixel queues drive the
// inputs, expected beats are queued as stimulus is loaded and popped as the
// output stream accepts beats.
module tb_pixel_src_arbiter;
  import pixel_arb_pkg::*;

  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] in_data [4];
  logic [3:0]        in_valid, in_last, in_ready;
  src_idx_t          sel, out_src;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, out_last, out_ready;

  always #5 clk = ~clk;

  pixel_src_arbiter #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data0  (in_data[0]),
    .in_data1  (in_data[1]),
    .in_data2  (in_data[2]),
    .in_data3  (in_data[3]),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  logic [8:0]  src_q [4][$];   // {last, data}
  logic [10:0] exp_q [$];      // {src, last, data}
  logic [3:0]  taken;
  int          hs_cnt [4];
  int          hs_log [$];
  int          cyc, n_chk, n_err, n_stall;
  logic        pat_en, stall_prev;
  logic [10:0] held;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic chk_rst();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_out_last",  out_last, 0);
    chk("rst_out_src",   out_src, 0);
    chk("rst_sel",       sel, 0);
    chk("rst_in_ready",  in_ready, 0);
  endtask

  task automatic src_load(input int s, input int base, input int n, input int last_k);
    for (int k = 0; k < n; k++) src_q[s].push_back({(k == last_k), 8'(base + k)});
  endtask

  task automatic exp_push(input int s, input int base, input int k0, input int n, input int last_k);
    for (int k = k0; k < k0 + n; k++) exp_q.push_back({2'(s), (k == last_k), 8'(base + k)});
  endtask

  // One cycle: retire last cycle's accepted pixels, present queue heads,
  // then check the output side half a cycle away from the clock edge.
  task automatic step();
    logic [10:0] e;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (taken[i]) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0) begin
        in_valid[i] = 1'b1;
        in_last[i]  = src_q[i][0][8];
        in_data[i]  = src_q[i][0][7:0];
      end else begin
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
        in_data[i]  = '0;
      end
    end
    taken = '0;
    out_ready = pat_en ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
    #1;
    if (stall_prev) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_beat", {out_src, out_last, out_data}, held);
    end
    stall_prev = out_valid && !out_ready;
    if (stall_prev) begin
      n_stall++;
      held = {out_src, out_last, out_data};
      chk("stall_in_ready", in_ready, 0);
    end
    chk("in_ready_onehot", ($countones(in_ready) <= 1), 1);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_beat_expq", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("beat", {out_src, out_last, out_data}, e);
      end
    end
    for (int i = 0; i < 4; i++)
      if (in_valid[i] && in_ready[i]) begin
        taken[i] = 1'b1;
        hs_cnt[i]++;
        hs_log.push_back(cyc);
      end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      src_q[i].delete();
      in_data[i] = '0;
      hs_cnt[i] = 0;
    end
    exp_q.delete();
    hs_log.delete();
    taken = '0; in_valid = '0; in_last = '0; out_ready = 1'b1;
    stall_prev = 1'b0; pat_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_rst();
  endtask

  task automatic run_drain(input string tag, input int budget);
    for (int b = 0; b < budget && exp_q.size() > 0; b++) step();
    chk(tag, exp_q.size(), 0);
    repeat (3) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_rdy;
    int p, g;
    n_chk = 0; n_err = 0; n_stall = 0; cyc = 0;

    // Single requester, 20 pixels: 16-beat burst, one idle cycle, 4 more.
    do_reset();
    src_load(2, 'h10, 20, -1);
    exp_push(2, 'h10, 0, 20, -1);
    run_drain("t1_drain", 100);
    chk("t1_hs_count", hs_log.size(), 20);
    if (hs_log.size() >= 17) begin
      chk("t1_throughput", hs_log[15] - hs_log[0], 15);
      chk("t1_idle_gap", hs_log[16] - hs_log[15], 2);
    end

    // All four requesting: grants 0,1,2,3,0 of 16 beats, one IDLE between.
    do_reset();
    src_load(0, 'h00, 32, -1);
    for (int s = 1; s < 4; s++) src_load(s, s * 'h40, 16, -1);
    for (int r = 0; r < 5; r++) exp_push(r % 4, (r % 4) * 'h40, (r == 4) ? 16 : 0, 16, -1);
    for (int c = 0; c < 86; c++) begin
      step();
      exp_rdy = '0;
      if (c > 0) begin
        p = (c - 1) % 17;
        g = ((c - 1) / 17) % 4;
        if (p < 16) begin
          exp_rdy = 4'(1 << g);
          chk("t2_sel", sel, g);
        end
      end
      chk("t2_in_ready", in_ready, exp_rdy);
    end
    run_drain("t2_drain", 20);

    // Source 1 ends its line on beat 5; source 3 is served next.
    do_reset();
    src_load(1, 'hA0, 5, 4);
    src_load(3, 'hC0, 3, 2);
    exp_push(1, 'hA0, 0, 5, 4);
    exp_push(3, 'hC0, 0, 3, 2);
    run_drain("t3_drain", 60);

    // Output backpressure 1,0,0,1: held data, no loss or duplication.
    do_reset();
    n_stall = 0;
    pat_en = 1'b1;
    src_load(0, 'h30, 6, 5);
    exp_push(0, 'h30, 0, 6, 5);
    run_drain("t4_drain", 80);
    pat_en = 1'b0;
    chk("t4_stalls_seen", (n_stall > 0), 1);

    // Reset at beat 7 of source 2's burst, after source 1 moved rr_ptr to 2.
    do_reset();
    src_load(1, 'h50, 2, 1);
    src_load(1, 'h52, 4, 3);
    src_load(2, 'h60, 20, 19);
    exp_push(1, 'h50, 0, 2, 1);
    exp_push(2, 'h60, 0, 6, -1);
    for (int b = 0; b < 60 && hs_cnt[2] < 7; b++) step();
    chk("t5_beats_before_rst", hs_cnt[2], 7);
    chk("t5_pre_rst_drain", exp_q.size(), 0);
    rst_n = 1'b0;
    taken = '0;
    stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_rst();
    // rr_ptr back at 0, so source 1 wins over the interrupted source 2.
    exp_push(1, 'h52, 0, 4, 3);
    exp_push(2, 'h60, 6, 14, 19);
    run_drain("t5_drain", 80);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_src_arbiter.md
# pixel_src_arbiter

Round-robin arbiter and sequencer that shares the 8-bit four-input pixel multiplexer between four pixel sources (e.g. camera, frame buffer, test pattern, filter output). It grants one source at a time for a burst of up to BURST_LEN pixels or until that source signals end-of-line. It drives the mux select and registers the selected pixel onto a single valid/ready output stream feeding the downstream filter pipeline.

## Interface

- DATA_W, default 8: pixel width.
- BURST_LEN, default 16: maximum beats per grant; legal range 1..256.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- in_data0..in_data3  in  DATA_W each  pixel from source 0..3.
- in_valid  in  4  per-source valid; bit i belongs to source i.
- in_last  in  4  per-source end-of-line marker, meaningful only with in_valid[i].
- in_ready  out  4  per-source ready; at most one bit high per cycle.
- sel  out  2  mux select, equal to the current grant index.
- out_data  out  DATA_W  registered selected pixel.
- out_valid  out  1  output beat valid.
- out_last  out  1  copy of the granted source's in_last for this beat.
- out_src  out  2  source index of this beat.
- out_ready  in  1  downstream accept.

## Operation

- States: IDLE, BURST.
- IDLE:
  - Scan in_valid starting at rr_ptr, then rr_ptr+1, ..., wrapping modulo 4.
  - On the first set bit g: register grant=g, clear beat_cnt, go to BURST.
  - If no bit is set, stay in IDLE.
  - in_ready = 0 in IDLE.
- BURST:
  - in_ready[grant] = (!out_valid || out_ready). All other in_ready bits are 0.
  - A beat transfers when in_valid[grant] && in_ready[grant]. The output register then loads in_data[grant], in_last[grant] and grant, and beat_cnt increments.
  - The burst ends on a transferring beat with in_last[grant]=1 or beat_cnt==BURST_LEN-1. On that cycle: rr_ptr = grant+1 (mod 4), next state IDLE.
  - If in_valid[grant] drops mid-burst, the grant is held; there is no preemption.
- Output register:
  - out_valid sets on a transfer.
  - out_valid clears when out_ready is high and no new transfer occurs.
  - Data holds stable while out_valid && !out_ready.
- sel is driven from the grant register; it changes only on the IDLE->BURST transition.
- beat_cnt width is clog2(BURST_LEN), minimum 1 bit. It never exceeds BURST_LEN-1.

## Timing

- Reset (rst_n low at a rising edge):
  - state=IDLE, grant=0, sel=0, rr_ptr=0, beat_cnt=0.
  - out_valid=0, out_data=0, out_last=0, out_src=0, in_ready=0.
- Reset mid-burst discards the partial burst. No beat is emitted after reset until a new grant.
- Grant latency: request seen in IDLE at cycle N -> BURST with sel valid at N+1 -> first beat transfers at N+1 at earliest -> out_valid at N+2.
- Throughput: one beat per cycle inside a burst when out_ready stays high.
- Every burst is followed by exactly one IDLE cycle, including when the same source is re-granted.
- Ties: sources requesting in the same cycle are served in rr_ptr order.
- Simultaneous last and count limit on one beat: ends the burst once; rr_ptr advances once.
- BURST_LEN=1: every beat ends its burst.
- Backpressure on the final beat: the transition to IDLE happens on the transfer cycle, not on the output drain.

## Structure

- Shared package pixel_arb_pkg holds:
  - the state enum (IDLE, BURST),
  - the SRC_NUM=4 constant,
  - the 2-bit source index type.
- Natural sub-module: pixel_mux4, a combinational 4:1 DATA_W mux selected by sel. It is instantiated once for data; in_last is a 4-bit vector indexed directly.
- Round-robin pick logic is a function in the package, taking the 4-bit request vector and a 2-bit pointer.

## Test plan

- Single requester: in_valid=4'b0100 with 20 continuous pixels 0x10..0x23, no last, BURST_LEN=16.
  - Expect 0x10..0x1F with out_src=2, then one idle cycle, then re-grant to source 2 for 0x20..0x23.
- All four requesting continuously from reset.
  - Expect grants 0,1,2,3,0 in that order, each exactly 16 beats, with one IDLE cycle between bursts.
- Source 1 asserts in_last on its 5th beat while sources 1 and 3 both request.
  - Expect a 5-beat burst with out_last=1 on beat 5, then the next grant goes to source 3.
- out_ready toggles 1,0,0,1 during a burst.
  - Expect out_data held stable while stalled, no beat lost or duplicated, and in_ready[grant] low during the stall.
- rst_n pulsed low for one cycle at beat 7 of a burst.
  - Next cycle: all outputs at reset values and rr_ptr=0.
  - Arbitration then restarts from source 0.
